// File: rtl/load_sequencer.sv
// load_sequencer: drives NUM_STEPS one-hot register-load strobes in order
// after a start request, each held STEP_CYCLES cycles, with busy/done/abort.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   start - request a run (sampled in IDLE, and in DONE with auto-restart)
//   abort - terminate a run in progress (LOAD only)
//   ld    - one-hot load strobes, ld[0] first
//   step  - index of the active strobe, 0 outside LOAD
//   busy  - high while strobing
//   done  - one-cycle pulse after the last strobe
//
// Optional feature: define LOAD_SEQ_AUTO_RESTART_EN to let DONE accept
// start and go straight back to LOAD.
module load_sequencer #(
    parameter int NUM_STEPS   = 3,
    parameter int STEP_CYCLES = 1,
    localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [NUM_STEPS-1:0] ld,
    output logic [SW-1:0]        step,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(STEP_CYCLES - 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            go;

    // A start only counts when abort is not asserted at the same edge.
    assign go = start && !abort;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = LOAD;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (step_q == LAST_STEP) begin
                        state_d = DONE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
`ifdef LOAD_SEQ_AUTO_RESTART_EN
                if (go) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
                step_d = '0;
                cnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are flopped from the next-state values so that they line
    // up with the state register and never see a combinational input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            ld   <= (state_d == LOAD) ? (NUM_STEPS'(1) << step_d) : '0;
            busy <= (state_d == LOAD);
            done <= (state_d == DONE);
        end
    end

    assign step = step_q;

endmodule

// File: tb/tb_load_sequencer.sv
// Testbench for load_sequencer: directed per-cycle vector tables over several
// parameterisations, plus a randomised one-hot / done-ordering check.
module tb_load_sequencer;

    logic clk = 1'b0;
    logic rst, start, abort;

    always #5 clk = ~clk;

    logic [2:0]  a_ld;  logic [1:0] a_step; logic a_busy, a_done;
    logic [3:0]  b_ld;  logic [1:0] b_step; logic b_busy, b_done;
    logic [3:0]  c_ld;  logic [1:0] c_step; logic c_busy, c_done;
    logic [1:0]  d_ld;  logic       d_step; logic d_busy, d_done;
    logic [15:0] e_ld;  logic [3:0] e_step; logic e_busy, e_done;

    load_sequencer #(.NUM_STEPS(3), .STEP_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ld(a_ld), .step(a_step), .busy(a_busy), .done(a_done));
    load_sequencer #(.NUM_STEPS(4), .STEP_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ld(b_ld), .step(b_step), .busy(b_busy), .done(b_done));
    load_sequencer #(.NUM_STEPS(4), .STEP_CYCLES(2)) u_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ld(c_ld), .step(c_step), .busy(c_busy), .done(c_done));
    load_sequencer #(.NUM_STEPS(2), .STEP_CYCLES(1)) u_d (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ld(d_ld), .step(d_step), .busy(d_busy), .done(d_done));
    load_sequencer #(.NUM_STEPS(16), .STEP_CYCLES(5)) u_e (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ld(e_ld), .step(e_step), .busy(e_busy), .done(e_done));

    typedef struct {
        int          sel;
        logic        rst, start, abort, chk;
        logic [15:0] ld;
        logic [3:0]  step;
        logic        busy, done;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cur_sel = 0;

    logic [15:0] o_ld;
    logic [3:0]  o_step;
    logic        o_busy, o_done;

    always_comb begin
        o_ld = '0; o_step = '0; o_busy = 1'b0; o_done = 1'b0;
        case (cur_sel)
            0: begin o_ld = 16'(a_ld); o_step = 4'(a_step);
                     o_busy = a_busy; o_done = a_done; end
            1: begin o_ld = 16'(b_ld); o_step = 4'(b_step);
                     o_busy = b_busy; o_done = b_done; end
            2: begin o_ld = 16'(c_ld); o_step = 4'(c_step);
                     o_busy = c_busy; o_done = c_done; end
            3: begin o_ld = 16'(d_ld); o_step = 4'(d_step);
                     o_busy = d_busy; o_done = d_done; end
            default: begin o_ld = e_ld; o_step = e_step;
                     o_busy = e_busy; o_done = e_done; end
        endcase
    end

    task automatic add(input int s, input logic r, input logic st,
                       input logic ab, input logic ck, input logic [15:0] l,
                       input logic [3:0] sp, input logic b, input logic d);
        vec_t x;
        x.sel = s; x.rst = r; x.start = st; x.abort = ab; x.chk = ck;
        x.ld = l; x.step = sp; x.busy = b; x.done = d;
        vq.push_back(x);
    endtask

    // Reset cycle: outputs not checked in the cycle rst is applied.
    task automatic rv(input int s);
        add(s, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic v(input int s, input logic st, input logic ab,
                     input logic [15:0] l, input logic [3:0] sp,
                     input logic b, input logic d);
        add(s, 1'b0, st, ab, 1'b1, l, sp, b, d);
    endtask

    task automatic fail(input string name, input string msg);
        n_bad++;
        $display("FAIL %s: %s", name, msg);
    endtask

    int run15;
    logic one_hot_ok, map_ok;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;

        // A: 3 steps x 1 cycle -- reset mid-run, basic run, start+abort
        rv(0);
        v(0, 1, 0, 16'h0, 0, 0, 0);
        v(0, 0, 0, 16'h1, 0, 1, 0);
        add(0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2, 4'd1, 1'b1, 1'b0);
        v(0, 0, 0, 16'h0, 0, 0, 0);
        v(0, 0, 0, 16'h0, 0, 0, 0);
        v(0, 1, 0, 16'h0, 0, 0, 0);
        v(0, 0, 0, 16'h1, 0, 1, 0);
        v(0, 0, 0, 16'h2, 1, 1, 0);
        v(0, 0, 0, 16'h4, 2, 1, 0);
        v(0, 0, 0, 16'h0, 0, 0, 1);
        v(0, 1, 1, 16'h0, 0, 0, 0);
        v(0, 1, 1, 16'h0, 0, 0, 0);
        v(0, 0, 0, 16'h0, 0, 0, 0);

        // B: 4 steps x 3 cycles
        rv(1);
        v(1, 1, 0, 16'h0, 0, 0, 0);
        for (int c = 1; c <= 12; c++)
            v(1, 0, 0, 16'(1) << ((c - 1) / 3), 4'((c - 1) / 3), 1, 0);
        v(1, 0, 0, 16'h0, 0, 0, 1);
        v(1, 0, 0, 16'h0, 0, 0, 0);

        // C: 4 steps x 2 cycles, abort during ld[1], abort ignored in IDLE
        rv(2);
        v(2, 1, 0, 16'h0, 0, 0, 0);
        v(2, 0, 0, 16'h1, 0, 1, 0);
        v(2, 0, 0, 16'h1, 0, 1, 0);
        v(2, 0, 0, 16'h2, 1, 1, 0);
        v(2, 0, 1, 16'h2, 1, 1, 0);
        v(2, 0, 1, 16'h0, 0, 0, 0);
        v(2, 1, 0, 16'h0, 0, 0, 0);
        v(2, 0, 0, 16'h1, 0, 1, 0);
        v(2, 0, 0, 16'h1, 0, 1, 0);
        v(2, 0, 0, 16'h2, 1, 1, 0);

        // D: 2 steps x 1 cycle, start held high
        rv(3);
        v(3, 1, 0, 16'h0, 0, 0, 0);
        v(3, 1, 0, 16'h1, 0, 1, 0);
        v(3, 1, 0, 16'h2, 1, 1, 0);
        v(3, 1, 0, 16'h0, 0, 0, 1);
`ifdef LOAD_SEQ_AUTO_RESTART_EN
        v(3, 1, 0, 16'h1, 0, 1, 0);
        v(3, 1, 0, 16'h2, 1, 1, 0);
        v(3, 1, 0, 16'h0, 0, 0, 1);
        v(3, 0, 0, 16'h1, 0, 1, 0);
`else
        v(3, 1, 0, 16'h0, 0, 0, 0);
        v(3, 1, 0, 16'h1, 0, 1, 0);
        v(3, 1, 0, 16'h2, 1, 1, 0);
        v(3, 0, 0, 16'h0, 0, 0, 1);
        v(3, 0, 0, 16'h0, 0, 0, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        foreach (vq[i]) begin
            cur_sel = vq[i].sel;
            rst = vq[i].rst; start = vq[i].start; abort = vq[i].abort;
            #1;
            if (vq[i].chk) begin
                n_vec++;
                if ({o_ld, o_step, o_busy, o_done} !==
                    {vq[i].ld, vq[i].step, vq[i].busy, vq[i].done})
                    fail($sformatf("vec%0d", i), $sformatf(
                        "sel=%0d ld=%h step=%0d busy=%b done=%b, want ld=%h step=%0d busy=%b done=%b",
                        vq[i].sel, o_ld, o_step, o_busy, o_done,
                        vq[i].ld, vq[i].step, vq[i].busy, vq[i].done));
            end
            @(posedge clk);
            #1;
        end

        // Random stress on 16 steps x 5 cycles
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run15 = 0;
        for (int i = 0; i < 10000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            abort = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            one_hot_ok = ($countones(e_ld) <= 1);
            n_vec++;
            if (!one_hot_ok)
                fail("onehot", $sformatf("ld=%h", e_ld));
            if (e_busy) map_ok = (e_ld[e_step] == 1'b1) && one_hot_ok
                                 && (e_ld != 16'h0);
            else        map_ok = (e_ld == 16'h0) && (e_step == 4'h0);
            n_vec++;
            if (!map_ok)
                fail("ldstep", $sformatf("busy=%b ld=%h step=%0d",
                     e_busy, e_ld, e_step));
            if (e_done) begin
                n_vec++;
                if (run15 != 5)
                    fail("doneorder", $sformatf(
                         "ld[15] run before done=%0d, want 5", run15));
            end
            run15 = e_ld[15] ? run15 + 1 : 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
